// File: rtl/snake_head_mover.sv
// snake_head_mover: game-tick stage that advances the snake head one cell per
// tick and detects wall collisions.
// Optional feature macro: SNAKE_WRAP_EN -- edges wrap around instead of killing
// the snake (DEAD becomes unreachable and `dead` is tied low).
module snake_head_mover #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int TICK_DIV = 25_000_000,
  parameter int START_X  = 4,
  parameter int START_Y  = 8,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    direction,
  input  logic          start,
  input  logic          pause,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic          step,
  output logic          running,
  output logic          dead
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [XW-1:0] X_MAX     = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_START   = XW'(START_X);
  localparam logic [YW-1:0] Y_START   = YW'(START_Y);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] head_x_q, head_x_d;
  logic [YW-1:0] head_y_q, head_y_d;
  logic          step_q, step_d;

  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic          wall_hit;

  // Candidate next head position for the sampled direction, plus wall detection.
  always_comb begin
    next_x   = head_x_q;
    next_y   = head_y_q;
    wall_hit = 1'b0;
    case (direction)
      2'b00: begin
        if (head_x_q == X_MAX) begin
`ifdef SNAKE_WRAP_EN
          next_x = '0;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          next_x = head_x_q + XW'(1);
        end
      end
      2'b01: begin
        if (head_y_q == Y_MAX) begin
`ifdef SNAKE_WRAP_EN
          next_y = '0;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          next_y = head_y_q + YW'(1);
        end
      end
      2'b10: begin
        if (head_x_q == '0) begin
`ifdef SNAKE_WRAP_EN
          next_x = X_MAX;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          next_x = head_x_q - XW'(1);
        end
      end
      default: begin
        if (head_y_q == '0) begin
`ifdef SNAKE_WRAP_EN
          next_y = Y_MAX;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          next_y = head_y_q - YW'(1);
        end
      end
    endcase
  end

  // Next-state logic: start/restart, tick counting with pause, move or die.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    head_x_d = head_x_q;
    head_y_d = head_y_q;
    step_d   = 1'b0;
    case (state_q)
      RUN: begin
        // Pause takes priority over the terminal count, so the counter may sit at TICK_LAST.
        if (!pause) begin
          if (cnt_q == TICK_LAST) begin
            cnt_d = '0;
            if (wall_hit) begin
              state_d = DEAD;
            end else begin
              head_x_d = next_x;
              head_y_d = next_y;
              step_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        // IDLE and DEAD both restart the same way on start.
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          head_x_d = X_START;
          head_y_d = Y_START;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      head_x_q <= X_START;
      head_y_q <= Y_START;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      head_x_q <= head_x_d;
      head_y_q <= head_y_d;
      step_q   <= step_d;
    end
  end

  assign head_x  = head_x_q;
  assign head_y  = head_y_q;
  assign step    = step_q;
  assign running = (state_q == RUN);
`ifdef SNAKE_WRAP_EN
  assign dead    = 1'b0;
`else
  assign dead    = (state_q == DEAD);
`endif

endmodule

// File: tb/tb_snake_head_mover.sv
// Directed testbench for snake_head_mover (GRID 8x8, TICK_DIV=4, start (6,0)).
// Expectations follow SNAKE_WRAP_EN when it is defined for the build.
module tb_snake_head_mover;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] direction = 2'b00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] head_x;
  logic [2:0] head_y;
  logic       step;
  logic       running;
  logic       dead;

  int errors = 0;
  int checks = 0;

  snake_head_mover #(
    .GRID_W(8),
    .GRID_H(8),
    .TICK_DIV(4),
    .START_X(6),
    .START_Y(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .direction(direction),
    .start(start),
    .pause(pause),
    .head_x(head_x),
    .head_y(head_y),
    .step(step),
    .running(running),
    .dead(dead)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  // Pulse start for one edge with the given direction.
  task automatic do_start(input logic [1:0] dir);
    direction = dir;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({head_x, head_y, step, running, dead} !== {3'd6, 3'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: got x=%0d y=%0d step=%b run=%b dead=%b, want x=6 y=0 step=0 run=0 dead=0",
               head_x, head_y, step, running, dead);
    end
  endtask

  task automatic test_right_wall();
    do_reset();
    do_start(2'b00);
    checks++;
    if ({running, step, dead, head_x, head_y} !== {3'b100, 3'd6, 3'd0}) begin
      errors++;
      $display("FAIL start_run: got run=%b step=%b dead=%b x=%0d y=%0d, want run=1 step=0 dead=0 x=6 y=0",
               running, step, dead, head_x, head_y);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (step !== 1'b0) begin
        errors++;
        $display("FAIL right_early_step: cycle %0d got step=%b, want 0", i, step);
      end
    end
    cyc();
    checks++;
    if ({step, head_x, head_y} !== {1'b1, 3'd7, 3'd0}) begin
      errors++;
      $display("FAIL right_first_tick: got step=%b x=%0d y=%0d, want step=1 x=7 y=0", step, head_x, head_y);
    end
    for (int i = 0; i < 4; i++) cyc();
`ifdef SNAKE_WRAP_EN
    checks++;
    if ({step, running, dead, head_x, head_y} !== {3'b110, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL right_wrap: got step=%b run=%b dead=%b x=%0d y=%0d, want step=1 run=1 dead=0 x=0 y=0",
               step, running, dead, head_x, head_y);
    end
`else
    checks++;
    if ({step, running, dead, head_x, head_y} !== {3'b001, 3'd7, 3'd0}) begin
      errors++;
      $display("FAIL right_wall: got step=%b run=%b dead=%b x=%0d y=%0d, want step=0 run=0 dead=1 x=7 y=0",
               step, running, dead, head_x, head_y);
    end
`endif
  endtask

  task automatic test_up_wall();
    do_reset();
    do_start(2'b11);
    for (int i = 0; i < 4; i++) cyc();
`ifdef SNAKE_WRAP_EN
    checks++;
    if ({step, running, dead, head_x, head_y} !== {3'b110, 3'd6, 3'd7}) begin
      errors++;
      $display("FAIL up_wrap: got step=%b run=%b dead=%b x=%0d y=%0d, want step=1 run=1 dead=0 x=6 y=7",
               step, running, dead, head_x, head_y);
    end
`else
    checks++;
    if ({step, running, dead, head_x, head_y} !== {3'b001, 3'd6, 3'd0}) begin
      errors++;
      $display("FAIL up_wall: got step=%b run=%b dead=%b x=%0d y=%0d, want step=0 run=0 dead=1 x=6 y=0",
               step, running, dead, head_x, head_y);
    end
`endif
  endtask

  // Continues from test_up_wall: restart from DEAD (or start ignored while running when wrapping).
  task automatic test_restart();
`ifdef SNAKE_WRAP_EN
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if ({running, dead, head_x, head_y} !== {2'b10, 3'd6, 3'd7}) begin
      errors++;
      $display("FAIL start_ignored_in_run: got run=%b dead=%b x=%0d y=%0d, want run=1 dead=0 x=6 y=7",
               running, dead, head_x, head_y);
    end
`else
    direction = 2'b01;
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if ({running, dead, step, head_x, head_y} !== {3'b100, 3'd6, 3'd0}) begin
      errors++;
      $display("FAIL restart_dead: got run=%b dead=%b step=%b x=%0d y=%0d, want run=1 dead=0 step=0 x=6 y=0",
               running, dead, step, head_x, head_y);
    end
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if (step !== 1'b0) begin
      errors++;
      $display("FAIL restart_early_step: got step=%b, want 0", step);
    end
    cyc();
    checks++;
    if ({step, head_x, head_y} !== {1'b1, 3'd6, 3'd1}) begin
      errors++;
      $display("FAIL restart_first_tick: got step=%b x=%0d y=%0d, want step=1 x=6 y=1", step, head_x, head_y);
    end
`endif
  endtask

  task automatic test_pause();
    do_reset();
    do_start(2'b01);
    cyc();
    cyc();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if ({step, running, head_x, head_y} !== {2'b01, 3'd6, 3'd0}) begin
        errors++;
        $display("FAIL pause_hold: cycle %0d got step=%b run=%b x=%0d y=%0d, want step=0 run=1 x=6 y=0",
                 i, step, running, head_x, head_y);
      end
    end
    pause = 1'b0;
    cyc();
    checks++;
    if (step !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume_early: got step=%b, want 0", step);
    end
    cyc();
    checks++;
    if ({step, head_x, head_y} !== {1'b1, 3'd6, 3'd1}) begin
      errors++;
      $display("FAIL pause_resume_tick: got step=%b x=%0d y=%0d, want step=1 x=6 y=1", step, head_x, head_y);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (step !== 1'b0) begin
        errors++;
        $display("FAIL steady_gap: cycle %0d got step=%b, want 0", i, step);
      end
    end
    cyc();
    checks++;
    if ({step, head_x, head_y} !== {1'b1, 3'd6, 3'd2}) begin
      errors++;
      $display("FAIL steady_tick: got step=%b x=%0d y=%0d, want step=1 x=6 y=2", step, head_x, head_y);
    end
  endtask

  task automatic test_dir_change();
    do_reset();
    do_start(2'b01);
    for (int i = 0; i < 3; i++) cyc();
    direction = 2'b10;
    cyc();
    checks++;
    if ({step, head_x, head_y} !== {1'b1, 3'd5, 3'd0}) begin
      errors++;
      $display("FAIL dir_change_tick: got step=%b x=%0d y=%0d, want step=1 x=5 y=0", step, head_x, head_y);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_start(2'b00);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if ({head_x, head_y, step, running, dead} !== {3'd6, 3'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_mid: got x=%0d y=%0d step=%b run=%b dead=%b, want x=6 y=0 step=0 run=0 dead=0",
               head_x, head_y, step, running, dead);
    end
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++;
      if ({step, running, head_x, head_y} !== {2'b00, 3'd6, 3'd0}) begin
        errors++;
        $display("FAIL reset_mid_idle: cycle %0d got step=%b run=%b x=%0d y=%0d, want step=0 run=0 x=6 y=0",
                 i, step, running, head_x, head_y);
      end
    end
  endtask

  initial begin
    cyc();
    test_reset();
    test_right_wall();
    test_up_wall();
    test_restart();
    test_pause();
    test_dir_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
